// File: rtl/gpr_pkg.sv
// Shared types and constants for the GPR writeback path.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a. Provides register/data widths, the $0 constant, the LU FIFO entry struct and a onehot helper.
package gpr_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  // One queued long-latency result; kill marks it as superseded by a younger pipeline write.
  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              kill;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/gpr_wb_arbiter_if.sv
// GPR write-port bundle: pipeline writeback, LU result handshake, GPR write port and hazard outputs.
// Latency: n/a (wires only).
// Backpressure: lu_ready back to the LU. master = arbiter side, slave = pipeline/LU/regfile side.
interface gpr_wb_arbiter_if;
  import gpr_pkg::*;

  logic                pipe_we;
  logic [REG_AW-1:0]   pipe_addr;
  logic [DATA_W-1:0]   pipe_data;
  logic                lu_valid;
  logic [REG_AW-1:0]   lu_addr;
  logic [DATA_W-1:0]   lu_data;
  logic                lu_ready;
  logic                WE;
  logic [REG_AW-1:0]   A3_WB;
  logic [DATA_W-1:0]   WD;
  logic [NUM_REGS-1:0] busy_mask;
  logic                stall_req;

  modport master (
    input  pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
    output lu_ready, WE, A3_WB, WD, busy_mask, stall_req
  );

  modport slave (
    output pipe_we, pipe_addr, pipe_data, lu_valid, lu_addr, lu_data,
    input  lu_ready, WE, A3_WB, WD, busy_mask, stall_req
  );

endinterface

// File: rtl/gpr_wb_arbiter_wb_fifo.sv
// wb_fifo: LU result queue with per-entry kill bits matched against a register address.
// Latency: push visible at head the cycle after the edge; pop takes effect at the edge.
// Backpressure: full; push is ignored when full, pop ignored when empty.
// Ports: Clk/Reset; push + push_addr/push_data; pop; kill_en/kill_addr; full/empty; head entry; live/slot_addr per slot.
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         push,
  input  logic [REG_AW-1:0]            push_addr,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  input  logic                         kill_en,
  input  logic [REG_AW-1:0]            kill_addr,
  output logic                         full,
  output logic                         empty,
  output wb_entry_t                    head,
  output logic [DEPTH-1:0]             live,
  output logic [DEPTH-1:0][REG_AW-1:0] slot_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [DEPTH-1:0]  kill_q;
  logic [DEPTH-1:0]  occ;
  logic [REG_AW-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // A slot is occupied when its distance from the read pointer (mod DEPTH) is below count.
  always_comb begin
    logic [PW-1:0] off;
    occ       = '0;
    live      = '0;
    slot_addr = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr;
      occ[i]       = ({1'b0, off} < count);
      live[i]      = occ[i] && !kill_q[i];
      slot_addr[i] = addr_q[i];
    end
  end

  assign head = '{addr: addr_q[rd_ptr], data: data_q[rd_ptr], kill: kill_q[rd_ptr]};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      kill_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en && occ[i] && (addr_q[i] == kill_addr))
          kill_q[i] <= 1'b1;
      end
      // The tail slot is never occupied when push_ok, so this cannot undo a kill.
      if (push_ok) begin
        kill_q[wr_ptr] <= 1'b0;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy gates every use of it.
  always_ff @(posedge Clk) begin
    if (push_ok) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/gpr_wb_arbiter.sv
// GPR write-port master: merges MEM/WB writeback with buffered long-latency results into one write port.
// Latency: pipeline write same cycle; LU result earliest the cycle after acceptance.
// Backpressure: lu_ready = !full (no same-cycle pop credit); stall_req asks for a bubble when the head starves.
// Ports: Clk, Reset (async, active-high), bus (gpr_wb_arbiter_if.master).
module gpr_wb_arbiter
  import gpr_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 7
) (
  input  logic Clk,
  input  logic Reset,
  gpr_wb_arbiter_if.master bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  logic                         pipe_wr;
  logic                         head_vld;
  logic                         pop;
  logic                         push;
  logic                         fifo_full;
  logic                         fifo_empty;
  wb_entry_t                    head;
  logic [DEPTH-1:0]             live;
  logic [DEPTH-1:0][REG_AW-1:0] slot_addr;
  logic [WW-1:0]                wait_cnt;
  logic                         stall_q;

  // Writes to $0 are no-ops; gating with Reset keeps WE low while reset is held.
  assign pipe_wr  = bus.pipe_we && (bus.pipe_addr != REG_ZERO) && !Reset;
  assign head_vld = !fifo_empty;
  // Killed heads also pop here (with WE low) so draining is uniform.
  assign pop      = head_vld && !pipe_wr;
  // $0 results complete the handshake but are dropped.
  assign push     = bus.lu_valid && !fifo_full && (bus.lu_addr != REG_ZERO);

  assign bus.lu_ready  = !fifo_full;
  assign bus.stall_req = stall_q;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push),
    .push_addr (bus.lu_addr),
    .push_data (bus.lu_data),
    .pop       (pop),
    .kill_en   (pipe_wr),
    .kill_addr (bus.pipe_addr),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .live      (live),
    .slot_addr (slot_addr)
  );

  always_comb begin
    bus.WE    = 1'b0;
    bus.A3_WB = REG_ZERO;
    bus.WD    = '0;
    if (pipe_wr) begin
      bus.WE    = 1'b1;
      bus.A3_WB = bus.pipe_addr;
      bus.WD    = bus.pipe_data;
    end else if (pop && !head.kill) begin
      bus.WE    = 1'b1;
      bus.A3_WB = head.addr;
      bus.WD    = head.data;
    end
  end

  // Built purely from FIFO state: no combinational path from the lu_* inputs.
  always_comb begin
    bus.busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i])
        bus.busy_mask = bus.busy_mask | reg_onehot(slot_addr[i]);
    end
  end

  // A valid head that does not pop is necessarily blocked by a pipeline write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else if (!head_vld || pop) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (wait_cnt != WW'(MAX_WAIT))
        wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == WW'(MAX_WAIT))
        stall_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Scoreboard bench for gpr_wb_arbiter: queue-based reference model, directed scenarios then random traffic.
// Latency: expectations are pushed at posedge+1 and compared at the following negedge.
// Backpressure: the model honours lu_ready exactly as the LU would.
module tb_gpr_wb_arbiter;
  import gpr_pkg::*;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 7;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  gpr_wb_arbiter_if bus();

  gpr_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] busy;
    logic        ready;
    logic        stall;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          kill;
  } mentry_t;

  exp_t    expq[$];
  mentry_t mq[$];
  int      m_wait;
  bit      m_stall;
  int      checks;
  int      errors;
  int      cycle;

  // Monitor: one expectation per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checks++;
        if ({bus.WE, bus.A3_WB, bus.WD} !== {e.we, e.addr, e.data}) begin
          errors++;
          $display("FAIL wport cyc=%0d got we=%b a=%0d d=%h exp we=%b a=%0d d=%h",
                   e.cyc, bus.WE, bus.A3_WB, bus.WD, e.we, e.addr, e.data);
        end
        checks++;
        if (bus.busy_mask !== e.busy) begin
          errors++;
          $display("FAIL busy_mask cyc=%0d got %h exp %h", e.cyc, bus.busy_mask, e.busy);
        end
        checks++;
        if (bus.lu_ready !== e.ready) begin
          errors++;
          $display("FAIL lu_ready cyc=%0d got %b exp %b", e.cyc, bus.lu_ready, e.ready);
        end
        checks++;
        if (bus.stall_req !== e.stall) begin
          errors++;
          $display("FAIL stall_req cyc=%0d got %b exp %b", e.cyc, bus.stall_req, e.stall);
        end
      end
    end
  end

  function automatic logic [31:0] model_busy();
    logic [31:0] m;
    m = '0;
    foreach (mq[k])
      if (!mq[k].kill) m[mq[k].addr] = 1'b1;
    return m;
  endfunction

  // One clock of stimulus plus the reference model's view of that cycle.
  task automatic cyc(input bit pwe, input logic [4:0] pa, input logic [31:0] pd,
                     input bit lv, input logic [4:0] la, input logic [31:0] ld);
    exp_t    e;
    mentry_t ne;
    bit      head, pipe_wr, pop, accept;
    bus.pipe_we   = pwe;
    bus.pipe_addr = pa;
    bus.pipe_data = pd;
    bus.lu_valid  = lv;
    bus.lu_addr   = la;
    bus.lu_data   = ld;

    head    = (mq.size() > 0);
    pipe_wr = pwe && (pa != 5'd0);
    pop     = head && !pipe_wr;
    e.cyc   = cycle;
    e.we    = 1'b0;
    e.addr  = '0;
    e.data  = '0;
    if (pipe_wr) begin
      e.we = 1'b1; e.addr = pa; e.data = pd;
    end else if (pop && !mq[0].kill) begin
      e.we = 1'b1; e.addr = mq[0].addr; e.data = mq[0].data;
    end
    e.busy  = model_busy();
    e.ready = (mq.size() < DEPTH);
    e.stall = m_stall;
    expq.push_back(e);

    accept = lv && (mq.size() < DEPTH);
    if (!head || pop) begin
      m_wait  = 0;
      m_stall = 1'b0;
    end else begin
      if (m_wait == MAX_WAIT) m_stall = 1'b1;
      if (m_wait < MAX_WAIT) m_wait++;
    end
    if (pop) void'(mq.pop_front());
    if (pipe_wr)
      foreach (mq[k]) if (mq[k].addr == pa) mq[k].kill = 1'b1;
    if (accept && la != 5'd0) begin
      ne.addr = la; ne.data = ld; ne.kill = 1'b0;
      mq.push_back(ne);
    end

    cycle++;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  // Reset with random pipeline/LU activity: everything must read as idle.
  task automatic do_reset(input int n);
    exp_t e;
    Reset = 1'b1;
    mq.delete();
    m_wait  = 0;
    m_stall = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.pipe_we   = 1'($urandom_range(0, 1));
      bus.pipe_addr = 5'($urandom_range(0, 31));
      bus.pipe_data = $urandom;
      bus.lu_valid  = 1'($urandom_range(0, 1));
      bus.lu_addr   = 5'($urandom_range(0, 31));
      bus.lu_data   = $urandom;
      e.cyc = cycle; e.we = 1'b0; e.addr = '0; e.data = '0;
      e.busy = '0; e.ready = 1'b1; e.stall = 1'b0;
      expq.push_back(e);
      cycle++;
      @(posedge Clk);
      #1;
    end
    Reset = 1'b0;
  endtask

  initial begin
    int pprob;
    checks = 0;
    errors = 0;
    cycle  = 0;
    Reset  = 1'b1;
    bus.pipe_we = 1'b0; bus.pipe_addr = '0; bus.pipe_data = '0;
    bus.lu_valid = 1'b0; bus.lu_addr = '0; bus.lu_data = '0;
    @(posedge Clk);
    #1;
    do_reset(2);

    // Idle port: accepted LU result written the next cycle.
    cyc(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF);
    idle(2);

    // Pipeline holds the port while the FIFO fills; 5th offer refused; then in-order drain.
    for (int i = 1; i <= 4; i++)
      cyc(1, 5'd20, 32'(i * 100), 1, 5'(i), 32'(i * 16));
    cyc(1, 5'd20, 32'd999, 1, 5'd9, 32'h99);
    idle(5);

    // Starvation: head blocked long enough to raise stall_req, then released.
    cyc(1, 5'd9, 32'h900, 1, 5'd12, 32'hAB);
    for (int i = 0; i < 10; i++) cyc(1, 5'd9, 32'(i), 0, 5'd0, 32'd0);
    idle(3);

    // WAW squash on $7.
    cyc(1, 5'd9, 32'h1, 1, 5'd7, 32'h11);
    cyc(1, 5'd7, 32'h22, 0, 5'd0, 32'd0);
    idle(2);

    // $0 handling on both sides.
    cyc(1, 5'd9, 32'h2, 1, 5'd3, 32'h33);
    cyc(1, 5'd0, 32'h55, 0, 5'd0, 32'd0);
    cyc(0, 5'd0, 32'd0, 1, 5'd0, 32'h77);
    idle(2);

    // Reset with three entries queued.
    for (int i = 1; i <= 3; i++) cyc(1, 5'd9, 32'(i), 1, 5'(i), 32'(i + 40));
    do_reset(2);
    idle(3);

    // Random traffic with phases of varying pipeline pressure.
    for (int c = 0; c < 3000; c++) begin
      case ((c / 150) % 4)
        0:       pprob = 20;
        1:       pprob = 95;
        2:       pprob = 60;
        default: pprob = 100;
      endcase
      if ($urandom_range(0, 299) == 0)
        do_reset(1);
      else
        cyc($urandom_range(0, 99) < pprob, 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end
    idle(8);

    @(negedge Clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations exp 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
